uart_core_cfg: RTL and testbench

Parametrised full-duplex UART and the next-generation replacement for the fixed 8N1 uart core. It adds configurable data width, parity and stop bits, 16x oversampled receive with start-bit glitch rejection, separate parity and framing error flags, and a TX FIFO with valid/ready handshake. It sits between the board serial pins and the Cipherbox byte-stream logic, one clock domain.

---
 rtl/uart_core_cfg.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: parameterised full-duplex UART.
//   TX: FIFO (valid/ready push) feeding a START/DATA/PARITY/STOP serialiser.
//   RX: 2-flop synchroniser, falling-edge start detect, 16x oversampled
//       mid-bit sampling, with parity and framing error flags.
// Ports:
//   clk, rst            master clock, asynchronous active-high reset
//   rx / tx             serial line in (async) / out
//   tx_valid, tx_data   push request and word; tx_ready = FIFO not full
//   tx_fifo_count       queued words, excluding the word being sent
//   tx_busy, rx_busy    FSM not idle
//   rx_valid            one-cycle pulse with rx_data / rx_parity_err / rx_frame_err
module uart_core_cfg #(
    parameter int BAUD_RATE     = 9600,
    parameter int SYS_CLK_FREQ  = 12000000,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    output logic                           tx,
    input  logic                           tx_valid,
    input  logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_ready,
    output logic [$clog2(TX_FIFO_DEPTH):0] tx_fifo_count,
    output logic                           tx_busy,
    output logic                           rx_valid,
    output logic [DATA_BITS-1:0]           rx_data,
    output logic                           rx_parity_err,
    output logic                           rx_frame_err,
    output logic                           rx_busy
);
    localparam int DIV_RAW    = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W      = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam int STOP_TICKS = STOP_BITS * 16;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 push, pop;
    state_t               tx_state;

    assign tx_ready = (tx_fifo_count < CNT_W'(TX_FIFO_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign pop      = (tx_state == S_IDLE) && (tx_fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   tx_fifo_count <= tx_fifo_count + CNT_W'(1);
                2'b01:   tx_fifo_count <= tx_fifo_count - CNT_W'(1);
                default: tx_fifo_count <= tx_fifo_count;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    // The baud prescaler restarts on every pop so each bit lasts exactly
    // 16*DIV clocks measured from the start edge.
    logic [DIV_W-1:0]     tx_div;
    logic [4:0]           tx_ticks;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tick;

    assign tx_tick = (tx_div == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_div   <= '0;
            tx_ticks <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            if (tx_state != S_IDLE) begin
                tx_div <= tx_tick ? '0 : tx_div + DIV_W'(1);
                if (tx_tick) tx_ticks <= tx_ticks + 5'd1;
            end
            case (tx_state)
                S_IDLE: if (pop) begin
                    tx_shift <= fifo_mem[rd_ptr];
                    // odd: bit set when the data holds an even number of ones
                    tx_par   <= (PARITY == 1) ? ~^fifo_mem[rd_ptr] : ^fifo_mem[rd_ptr];
                    tx_div   <= '0;
                    tx_ticks <= '0;
                    tx       <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_state <= S_START;
                end
                S_START: if (tx_tick && tx_ticks == 5'd15) begin
                    tx_ticks <= '0;
                    tx_bit   <= '0;
                    tx       <= tx_shift[0];
                    tx_state <= S_DATA;
                end
                S_DATA: if (tx_tick && tx_ticks == 5'd15) begin
                    tx_ticks <= '0;
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx       <= tx_par;
                            tx_state <= S_PARITY;
                        end else begin
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
                        end
                    end else begin
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                        tx_bit   <= tx_bit + BIT_W'(1);
                    end
                end
                S_PARITY: if (tx_tick && tx_ticks == 5'd15) begin
                    tx_ticks <= '0;
                    tx       <= 1'b1;
                    tx_state <= S_STOP;
                end
                S_STOP: if (tx_tick && tx_ticks == 5'(STOP_TICKS - 1)) begin
                    tx_ticks <= '0;
                    tx_busy  <= 1'b0;
                    tx_state <= S_IDLE;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX synchroniser ----------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- RX FSM ----------------
    // Prescaler restarts at the start edge, so tick 8 lands mid start bit
    // and every following 16th tick lands mid-bit.
    state_t               rx_state;
    logic [DIV_W-1:0]     rx_div;
    logic [3:0]           rx_ticks;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit, rx_stop_bit, rx_done;
    logic                 rx_tick, rx_ones_odd, rx_perr_next;

    assign rx_tick      = (rx_div == DIV_W'(DIV - 1));
    assign rx_ones_odd  = (^rx_shift) ^ rx_par_bit;
    assign rx_perr_next = (PARITY == 1) ? !rx_ones_odd :
                          (PARITY == 2) ?  rx_ones_odd : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= S_IDLE;
            rx_div        <= '0;
            rx_ticks      <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_stop_bit   <= 1'b1;
            rx_done       <= 1'b0;
            rx_busy       <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state != S_IDLE) begin
                rx_div <= rx_tick ? '0 : rx_div + DIV_W'(1);
                if (rx_tick) rx_ticks <= rx_ticks + 4'd1;
            end
            case (rx_state)
                // Edge (not level) detect: after a line break the receiver
                // waits for rx to return high before the next start.
                S_IDLE: if (rx_prev && !rx_s2) begin
                    rx_div   <= '0;
                    rx_ticks <= '0;
                    rx_busy  <= 1'b1;
                    rx_state <= S_START;
                end
                S_START: if (rx_tick && rx_ticks == 4'd7) begin
                    rx_ticks <= '0;
                    rx_bit   <= '0;
                    if (rx_s2) begin
                        rx_busy  <= 1'b0;       // glitch, not a start bit
                        rx_state <= S_IDLE;
                    end else begin
                        rx_state <= S_DATA;
                    end
                end
                S_DATA: if (rx_tick && rx_ticks == 4'd15) begin
                    rx_ticks <= '0;
                    rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == BIT_W'(DATA_BITS - 1))
                        rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        rx_bit <= rx_bit + BIT_W'(1);
                end
                S_PARITY: if (rx_tick && rx_ticks == 4'd15) begin
                    rx_ticks   <= '0;
                    rx_par_bit <= rx_s2;
                    rx_state   <= S_STOP;
                end
                S_STOP: begin
                    if (rx_done) begin
                        rx_data       <= rx_shift;
                        rx_parity_err <= rx_perr_next;
                        rx_frame_err  <= !rx_stop_bit;
                        rx_valid      <= 1'b1;
                        rx_done       <= 1'b0;
                        rx_busy       <= 1'b0;
                        rx_state      <= S_IDLE;
                    end else if (rx_tick && rx_ticks == 4'd15) begin
                        rx_stop_bit <= rx_s2;
                        rx_done     <= 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench: three DUTs at DIV=10 (one bit = 160 clk).
//   u0: 8N1, FIFO depth 4, rx looped from its own tx
//   u1: even parity, rx from own tx or from the bench driver (sel1)
//   u2: odd parity, rx looped from its own tx
module tb_uart_core_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic sel1 = 1'b1;
    logic rx_in1;

    logic       tv [3];
    logic [7:0] td [3];
    logic       tx_o [3], trdy [3], tbusy [3], rxv [3], perr [3], ferr [3], rbusy [3];
    logic [7:0] rxd_o [3];
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rx_in1 = sel1 ? tx_o[1] : rxd;

    uart_core_cfg #(.BAUD_RATE(10000), .SYS_CLK_FREQ(1600000), .PARITY(0), .TX_FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .rx(tx_o[0]), .tx(tx_o[0]), .tx_valid(tv[0]), .tx_data(td[0]),
        .tx_ready(trdy[0]), .tx_fifo_count(cnt0), .tx_busy(tbusy[0]), .rx_valid(rxv[0]),
        .rx_data(rxd_o[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_busy(rbusy[0]));

    uart_core_cfg #(.BAUD_RATE(10000), .SYS_CLK_FREQ(1600000), .PARITY(2), .TX_FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .rx(rx_in1), .tx(tx_o[1]), .tx_valid(tv[1]), .tx_data(td[1]),
        .tx_ready(trdy[1]), .tx_fifo_count(cnt1), .tx_busy(tbusy[1]), .rx_valid(rxv[1]),
        .rx_data(rxd_o[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_busy(rbusy[1]));

    uart_core_cfg #(.BAUD_RATE(10000), .SYS_CLK_FREQ(1600000), .PARITY(1), .TX_FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .rx(tx_o[2]), .tx(tx_o[2]), .tx_valid(tv[2]), .tx_data(td[2]),
        .tx_ready(trdy[2]), .tx_fifo_count(cnt2), .tx_busy(tbusy[2]), .rx_valid(rxv[2]),
        .rx_data(rxd_o[2]), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_busy(rbusy[2]));

    // rx_valid monitor: counts pulses, latches the delivered word, and counts
    // any pulse that lasts longer than one cycle.
    int         rv_cnt [3] = '{0, 0, 0};
    int         rv_dbl [3] = '{0, 0, 0};
    logic [7:0] rv_data [3];
    logic       rv_pe [3], rv_fe [3];
    logic       rv_prev [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv[i]) begin
                rv_cnt[i]  <= rv_cnt[i] + 1;
                rv_data[i] <= rxd_o[i];
                rv_pe[i]   <= perr[i];
                rv_fe[i]   <= ferr[i];
            end
            if (rxv[i] && rv_prev[i]) rv_dbl[i] <= rv_dbl[i] + 1;
            rv_prev[i] <= rxv[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Waits (bounded) for tx_busy, then samples tx mid-bit for every bit of
    // the frame. bits[k] = k-th bit on the line; len = busy cycles;
    // gap = cycles waited for busy; cnt = FIFO count when busy rose.
    task automatic tx_frame(input int i, output logic [15:0] bits, output int len,
                            output int gap, output int cnt);
        bits = '0;
        len  = 0;
        gap  = 0;
        while (!tbusy[i] && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        chk("tx_start_seen", {31'd0, tbusy[i]}, 1);
        cnt = get_cnt(i);
        while (tbusy[i] && len < 2500) begin
            if (len % 160 == 80) bits[len / 160] = tx_o[i];
            len++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [15:0] frame;   // line bits, LSB = start bit
        int          len;
    } tx_vec_t;

    typedef struct {
        logic [10:0] frame;   // {stop, parity, data[7:0], start}
        logic [7:0]  data;
        logic        pe;
        logic        fe;
    } rx_vec_t;

    tx_vec_t     tx_tab [8];
    rx_vec_t     rx_tab [4];
    logic [7:0]  words [6];
    int          exp_cnt [6];
    logic        exp_rdy [6];
    logic [15:0] bits;
    int          len, gap, cs, c0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_tab[0] = '{0, 8'hA5, 16'b1_1010_0101_0, 1600};
        tx_tab[1] = '{1, 8'h55, 16'b1_0_0101_0101_0, 1760};
        tx_tab[2] = '{2, 8'h55, 16'b1_1_0101_0101_0, 1760};
        tx_tab[3] = '{1, 8'h3C, 16'b1_0_0011_1100_0, 1760};
        tx_tab[4] = '{2, 8'h07, 16'b1_0_0000_0111_0, 1760};
        tx_tab[5] = '{0, 8'h00, 16'b1_0000_0000_0, 1600};
        tx_tab[6] = '{1, 8'hFF, 16'b1_0_1111_1111_0, 1760};
        tx_tab[7] = '{2, 8'hC3, 16'b1_1_1100_0011_0, 1760};

        rx_tab[0] = '{11'b0_1_0011_1100_0, 8'h3C, 1'b1, 1'b1};
        rx_tab[1] = '{11'b1_1_1010_0111_0, 8'hA7, 1'b0, 1'b0};
        rx_tab[2] = '{11'b1_1_0001_0010_0, 8'h12, 1'b1, 1'b0};
        rx_tab[3] = '{11'b0_1_1000_0000_0, 8'h80, 1'b0, 1'b1};

        words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            tv[i] = 1'b0;
            td[i] = 8'h00;
        end

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx_o[0]}, 1);
        chk("rst_tx_ready", {31'd0, trdy[0]}, 1);
        chk("rst_fifo_count", get_cnt(0), 0);
        chk("rst_tx_busy", {31'd0, tbusy[0]}, 0);
        chk("rst_rx_valid", {31'd0, rxv[0]}, 0);
        chk("rst_rx_data", {24'd0, rxd_o[0]}, 0);
        chk("rst_parity_err", {31'd0, perr[0]}, 0);
        chk("rst_frame_err", {31'd0, ferr[0]}, 0);
        chk("rst_rx_busy", {31'd0, rbusy[0]}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // TX frames with loopback receive
        for (int k = 0; k < 8; k++) begin
            c0 = rv_cnt[tx_tab[k].inst];
            tv[tx_tab[k].inst] = 1'b1;
            td[tx_tab[k].inst] = tx_tab[k].data;
            @(negedge clk);
            tv[tx_tab[k].inst] = 1'b0;
            tx_frame(tx_tab[k].inst, bits, len, gap, cs);
            chk("tx_frame_bits", {16'd0, bits}, {16'd0, tx_tab[k].frame});
            chk("tx_busy_len", len, tx_tab[k].len);
            chk("fifo_count_after_pop", cs, 0);
            repeat (20) @(negedge clk);
            chk("loop_rx_count", rv_cnt[tx_tab[k].inst] - c0, 1);
            chk("loop_rx_data", {24'd0, rv_data[tx_tab[k].inst]}, {24'd0, tx_tab[k].data});
            chk("loop_rx_perr", {31'd0, rv_pe[tx_tab[k].inst]}, 0);
            chk("loop_rx_ferr", {31'd0, rv_fe[tx_tab[k].inst]}, 0);
        end

        // RX frames driven by the bench into the even-parity receiver
        sel1 = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            c0 = rv_cnt[1];
            for (int b = 0; b < 11; b++) begin
                rxd = rx_tab[k].frame[b];
                repeat (160) @(negedge clk);
            end
            rxd = 1'b1;
            repeat (200) @(negedge clk);
            chk("rx_count", rv_cnt[1] - c0, 1);
            chk("rx_data", {24'd0, rv_data[1]}, {24'd0, rx_tab[k].data});
            chk("rx_parity_err", {31'd0, rv_pe[1]}, {31'd0, rx_tab[k].pe});
            chk("rx_frame_err", {31'd0, rv_fe[1]}, {31'd0, rx_tab[k].fe});
        end

        // start-bit glitch: 40 clk low
        c0 = rv_cnt[1];
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_rx_busy_high", {31'd0, rbusy[1]}, 1);
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_rx_busy_low_by_90", {31'd0, rbusy[1]}, 0);
        repeat (200) @(negedge clk);
        chk("glitch_no_rx_valid", rv_cnt[1] - c0, 0);

        // line break: one zero frame with frame error, then wait for high
        c0 = rv_cnt[1];
        rxd = 1'b0;
        repeat (3000) @(negedge clk);
        chk("break_count", rv_cnt[1] - c0, 1);
        chk("break_data", {24'd0, rv_data[1]}, 0);
        chk("break_ferr", {31'd0, rv_fe[1]}, 1);
        chk("break_perr", {31'd0, rv_pe[1]}, 0);
        chk("break_rx_idle_while_low", {31'd0, rbusy[1]}, 0);
        rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk("break_no_restart", rv_cnt[1] - c0, 1);
        sel1 = 1'b1;
        repeat (10) @(negedge clk);

        // FIFO depth 4: six pushes with tx_valid held high
        c0 = rv_cnt[0];
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    tv[0] = 1'b1;
                    td[0] = words[k];
                    @(negedge clk);
                    chk("fifo_fill_count", get_cnt(0), exp_cnt[k]);
                    chk("fifo_fill_ready", {31'd0, trdy[0]}, {31'd0, exp_rdy[k]});
                end
                tv[0] = 1'b0;
            end
            begin
                logic [15:0] fb;
                int          fl, fg, fc;
                for (int f = 0; f < 5; f++) begin
                    tx_frame(0, fb, fl, fg, fc);
                    chk("fifo_frame_bits", {16'd0, fb}, {22'd0, 1'b1, words[f], 1'b0});
                    chk("fifo_frame_len", fl, 1600);
                    if (f > 0) chk("fifo_back_to_back_gap", fg, 1);
                end
            end
        join
        repeat (20) @(negedge clk);
        chk("fifo_empty_after", get_cnt(0), 0);
        chk("fifo_loop_count", rv_cnt[0] - c0, 5);
        chk("fifo_loop_last", {24'd0, rv_data[0]}, 32'h55);

        // reset mid-DATA on TX and RX
        tv[0] = 1'b1;
        td[0] = 8'h3C;
        @(negedge clk);
        tv[0] = 1'b0;
        repeat (500) @(negedge clk);
        chk("pre_rst_tx_busy", {31'd0, tbusy[0]}, 1);
        chk("pre_rst_rx_busy", {31'd0, rbusy[0]}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx_o[0]}, 1);
        chk("mid_rst_tx_busy", {31'd0, tbusy[0]}, 0);
        chk("mid_rst_tx_ready", {31'd0, trdy[0]}, 1);
        chk("mid_rst_fifo_count", get_cnt(0), 0);
        chk("mid_rst_rx_busy", {31'd0, rbusy[0]}, 0);
        chk("mid_rst_rx_valid", {31'd0, rxv[0]}, 0);
        chk("mid_rst_rx_data", {24'd0, rxd_o[0]}, 0);
        chk("mid_rst_perr", {31'd0, perr[0]}, 0);
        chk("mid_rst_ferr", {31'd0, ferr[0]}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        c0 = rv_cnt[0];
        tv[0] = 1'b1;
        td[0] = 8'h81;
        @(negedge clk);
        tv[0] = 1'b0;
        tx_frame(0, bits, len, gap, cs);
        chk("post_rst_bits", {16'd0, bits}, {16'd0, 16'b1_1000_0001_0});
        chk("post_rst_len", len, 1600);
        repeat (20) @(negedge clk);
        chk("post_rst_rx_count", rv_cnt[0] - c0, 1);
        chk("post_rst_rx_data", {24'd0, rv_data[0]}, 32'h81);
        chk("post_rst_rx_ferr", {31'd0, rv_fe[0]}, 0);

        for (int i = 0; i < 3; i++) chk("rx_valid_single_cycle", rv_dbl[i], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
